// File: rtl/cpu_fsr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_fsr_ctrl_if
// Purpose  : Bundles the instruction handshake and the FSR/data-register
//            control signals of cpu_fsr_ctrl.
// Signals  : instr_valid / instr_ready / instruction_in  - instruction handshake
//            fsr_reg_out, stall                           - datapath inputs
//            instruction_reg_output, reg_address_mux_select,
//            load_fsr, load_ram, phase, busy, instr_done,
//            indf_fault                                   - controller outputs
// Modports : master - fetch/datapath side (drives the inputs)
//            slave  - controller side (cpu_fsr_ctrl)
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_fsr_ctrl_if #(
  parameter int IR_W = 12
);
  logic            instr_valid;
  logic            instr_ready;
  logic [IR_W-1:0] instruction_in;
  logic [7:0]      fsr_reg_out;
  logic            stall;
  logic [IR_W-1:0] instruction_reg_output;
  logic            reg_address_mux_select;
  logic            load_fsr;
  logic            load_ram;
  logic [1:0]      phase;
  logic            busy;
  logic            instr_done;
  logic            indf_fault;

  modport master (
    output instr_valid, instruction_in, fsr_reg_out, stall,
    input  instr_ready, instruction_reg_output, reg_address_mux_select,
           load_fsr, load_ram, phase, busy, instr_done, indf_fault
  );

  modport slave (
    input  instr_valid, instruction_in, fsr_reg_out, stall,
    output instr_ready, instruction_reg_output, reg_address_mux_select,
           load_fsr, load_ram, phase, busy, instr_done, indf_fault
  );
endinterface
`default_nettype wire

// File: rtl/cpu_fsr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_fsr_ctrl
// Purpose  : Four-phase (Q1..Q4) sequencer for the FSR/data-register datapath
//            of a PIC10-compatible CPU. Latches one instruction per handshake,
//            decodes file-register writes, resolves direct vs indirect (INDF)
//            addressing and issues load_fsr / load_ram in Q4.
// Ports    : clk  - system clock, rising edge
//            rst  - asynchronous, active-low reset
//            bus  - cpu_fsr_ctrl_if.slave (handshake, FSR value, stall,
//                   latched IR, mux select, strobes, phase, busy, done, fault)
// Options  : CPU_FSR_CTRL_INDF_GUARD_EN - when defined, an indirect write whose
//            FSR points at INDF (address 0) is suppressed and flagged on
//            indf_fault; otherwise it writes data address 0 and indf_fault
//            stays 0.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_fsr_ctrl #(
  parameter int                IR_W     = 12,
  parameter int                ADDR_W   = 5,
  parameter logic [ADDR_W-1:0] FSR_ADDR = 5'h04
) (
  input  logic          clk,
  input  logic          rst,
  cpu_fsr_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_Q1   = 3'd1;
  localparam logic [2:0] S_Q2   = 3'd2;
  localparam logic [2:0] S_Q3   = 3'd3;
  localparam logic [2:0] S_Q4   = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [IR_W-1:0]   ir_q;
  logic              write_f_q;
  logic              indirect_q;
  logic              load_fsr_q;
  logic              load_ram_q;
  logic              done_q;
  logic              fault_q;
  logic              ready;
  logic              accept;
  logic              enter_q4;
  logic              write_f_dec;
  logic              indirect_dec;
  logic              indf_hit;
  logic [ADDR_W-1:0] ea_next;
  logic [1:0]        phase_c;
  logic              unused_fsr_bits;

  // Only the low ADDR_W bits of FSR select a file register.
  assign unused_fsr_bits = &{1'b0, bus.fsr_reg_out[7:ADDR_W]};

  // Ready only in IDLE/Q4, and forced low while reset is held.
  assign ready    = rst && ((state == S_IDLE) || (state == S_Q4));
  assign accept   = bus.instr_valid && ready;
  assign enter_q4 = (state == S_Q3) && !bus.stall;

  // Decode straight from the incoming word so it is registered with the IR.
  assign write_f_dec  = ((bus.instruction_in[11:10] == 2'b00) && bus.instruction_in[5])
                     || (bus.instruction_in[11:9] == 3'b010);
  assign indirect_dec = (bus.instruction_in[ADDR_W-1:0] == '0);

  // FSR is sampled on the Q3->Q4 edge, so the datapath may update it up to Q3.
  assign ea_next = indirect_q ? bus.fsr_reg_out[ADDR_W-1:0] : ir_q[ADDR_W-1:0];

`ifdef CPU_FSR_CTRL_INDF_GUARD_EN
  assign indf_hit = write_f_q && indirect_q && (ea_next == '0);
`else
  assign indf_hit = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept)      state_next = S_Q1;
      S_Q1:    if (!bus.stall)  state_next = S_Q2;
      S_Q2:    if (!bus.stall)  state_next = S_Q3;
      S_Q3:    if (!bus.stall)  state_next = S_Q4;
      S_Q4:    state_next = accept ? S_Q1 : S_IDLE;  // Q4 ignores stall
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    phase_c = 2'd0;
    case (state)
      S_Q2:    phase_c = 2'd1;
      S_Q3:    phase_c = 2'd2;
      S_Q4:    phase_c = 2'd3;
      default: phase_c = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      ir_q       <= '0;
      write_f_q  <= 1'b0;
      indirect_q <= 1'b0;
      load_fsr_q <= 1'b0;
      load_ram_q <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state      <= state_next;
      load_fsr_q <= 1'b0;
      load_ram_q <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;

      if (accept) begin
        ir_q       <= bus.instruction_in;
        write_f_q  <= write_f_dec;
        indirect_q <= indirect_dec;
      end else if (state == S_Q4) begin
        // Returning to IDLE: the mux select must read 0 there.
        indirect_q <= 1'b0;
      end

      // Strobes are registered so they are exactly the Q4 cycle.
      if (enter_q4) begin
        done_q     <= 1'b1;
        fault_q    <= indf_hit;
        load_fsr_q <= write_f_q && !indf_hit && (ea_next == FSR_ADDR);
        load_ram_q <= write_f_q && !indf_hit && (ea_next != FSR_ADDR);
      end
    end
  end

  assign bus.instr_ready            = ready;
  assign bus.instruction_reg_output = ir_q;
  assign bus.reg_address_mux_select = indirect_q;
  assign bus.load_fsr               = load_fsr_q;
  assign bus.load_ram               = load_ram_q;
  assign bus.phase                  = phase_c;
  assign bus.busy                   = (state != S_IDLE);
  assign bus.instr_done             = done_q;
  assign bus.indf_fault             = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_fsr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_fsr_ctrl
// Purpose  : Self-checking bench for cpu_fsr_ctrl. Each scenario pushes the
//            expected per-cycle output record to a scoreboard queue when it
//            drives stimulus, then pops and compares one record per clock.
//            Record = {IR, busy, ready, phase, mux_sel, load_fsr, load_ram,
//            done, fault}. Inputs change on the falling edge; outputs are
//            sampled on the falling edge.
// Options  : honours CPU_FSR_CTRL_INDF_GUARD_EN for the expected guard result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_fsr_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  typedef logic [20:0] rec_t;
  rec_t exp_q[$];

  cpu_fsr_ctrl_if #(.IR_W(12)) bus ();

  cpu_fsr_ctrl #(.IR_W(12), .ADDR_W(5), .FSR_ADDR(5'h04)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rec_t rec(input logic [11:0] ir, input logic busy, input logic ready,
                               input logic [1:0] ph, input logic mux, input logic lf,
                               input logic lr, input logic done, input logic flt);
    return {ir, busy, ready, ph, mux, lf, lr, done, flt};
  endfunction

  function automatic rec_t observe();
    return {bus.instruction_reg_output, bus.busy, bus.instr_ready, bus.phase,
            bus.reg_address_mux_select, bus.load_fsr, bus.load_ram,
            bus.instr_done, bus.indf_fault};
  endfunction

  // Expected Q1..Q4 records of one instruction, nstall extra Q2 cycles.
  function automatic void push_instr(input logic [11:0] ir, input logic [7:0] fsr,
                                     input int nstall);
    logic       wf, ind, lf, lr, flt;
    logic [4:0] ea;
    wf  = ((ir[11:10] == 2'b00) && ir[5]) || (ir[11:9] == 3'b010);
    ind = (ir[4:0] == 5'h00);
    ea  = ind ? fsr[4:0] : ir[4:0];
    flt = 1'b0;
`ifdef CPU_FSR_CTRL_INDF_GUARD_EN
    flt = wf && ind && (ea == 5'h00);
`endif
    lf  = wf && !flt && (ea == 5'h04);
    lr  = wf && !flt && (ea != 5'h04);
    exp_q.push_back(rec(ir, 1'b1, 1'b0, 2'd0, ind, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k <= nstall; k++)
      exp_q.push_back(rec(ir, 1'b1, 1'b0, 2'd1, ind, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(rec(ir, 1'b1, 1'b0, 2'd2, ind, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(rec(ir, 1'b1, 1'b1, 2'd3, ind, lf, lr, 1'b1, flt));
  endfunction

  function automatic void push_idle(input logic [11:0] ir);
    exp_q.push_back(rec(ir, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endfunction

  task automatic test_reset();
    rec_t e, o;
    // Power-on reset state, then idle after release.
    exp_q.push_back('0);
    push_idle(12'h000);
    // MOVWF 0x10 aborted in Q3: Q1..Q3, then reset (two clocks held), then idle.
    exp_q.push_back(rec(12'h030, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(rec(12'h030, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(rec(12'h030, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back('0);
    exp_q.push_back('0);
    exp_q.push_back('0);
    push_idle(12'h000);
    for (int i = 0; i < 9; i++) begin
      if (i == 6) #1; else @(negedge clk);
      e = exp_q.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset step %0d: got %h want %h", i, o, e);
      end
      case (i)
        0: rst = 1'b1;
        1: begin bus.instr_valid = 1'b1; bus.instruction_in = 12'h030; end
        2: bus.instr_valid = 1'b0;
        4: rst = 1'b0;            // asynchronous assert in the middle of Q3
        8: ;
        default: ;
      endcase
      if (i == 7) rst = 1'b1;
    end
  endtask

  task automatic test_direct();
    rec_t e, o;
    int   n;
    bus.instr_valid    = 1'b1;
    bus.instruction_in = 12'h030;
    push_instr(12'h030, bus.fsr_reg_out, 0);
    push_idle(12'h030);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL direct cyc %0d: got %h want %h", i, o, e);
      end
      if (i == 0) bus.instr_valid = 1'b0;
    end
  endtask

  task automatic test_indirect();
    rec_t       e, o;
    logic [7:0] fsr_tab [2];
    fsr_tab[0] = 8'h15;
    fsr_tab[1] = 8'h04;
    for (int t = 0; t < 2; t++) begin
      bus.fsr_reg_out    = fsr_tab[t];
      bus.instr_valid    = 1'b1;
      bus.instruction_in = 12'h020;
      push_instr(12'h020, fsr_tab[t], 0);
      push_idle(12'h020);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        e = exp_q.pop_front();
        o = observe();
        n_cmp++;
        if (o !== e) begin
          n_err++;
          $display("FAIL indirect fsr=%h cyc %0d: got %h want %h", fsr_tab[t], i, o, e);
        end
        if (i == 0) bus.instr_valid = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    rec_t e, o;
    int   n;
    bus.fsr_reg_out    = 8'h00;
    bus.instr_valid    = 1'b1;
    bus.instruction_in = 12'h024;
    push_instr(12'h024, 8'h00, 0);
    push_instr(12'h1D1, 8'h00, 0);
    push_idle(12'h1D1);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL back_to_back cyc %0d: got %h want %h", i, o, e);
      end
      if (i == 0) bus.instruction_in = 12'h1D1;  // valid held high
      if (i == 4) bus.instr_valid = 1'b0;
    end
  endtask

  task automatic test_stall();
    rec_t e, o;
    int   n;
    bus.instr_valid    = 1'b1;
    bus.instruction_in = 12'h072;
    push_instr(12'h072, bus.fsr_reg_out, 3);
    push_idle(12'h072);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL stall cyc %0d: got %h want %h", i, o, e);
      end
      case (i)
        0: bus.instr_valid = 1'b0;
        1: bus.stall = 1'b1;       // three stalled edges while in Q2
        4: bus.stall = 1'b0;
        6: bus.stall = 1'b1;       // must not hold Q4
        7: bus.stall = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_guard();
    rec_t e, o;
    bus.fsr_reg_out    = 8'h00;
    bus.instr_valid    = 1'b1;
    bus.instruction_in = 12'h560;
    push_instr(12'h560, 8'h00, 0);
    push_idle(12'h560);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL guard cyc %0d: got %h want %h", i, o, e);
      end
      if (i == 0) bus.instr_valid = 1'b0;
    end
  endtask

  initial begin
    n_cmp              = 0;
    n_err              = 0;
    rst                = 1'b0;
    bus.instr_valid    = 1'b0;
    bus.instruction_in = 12'h000;
    bus.fsr_reg_out    = 8'h00;
    bus.stall          = 1'b0;
    test_reset();
    test_direct();
    test_indirect();
    test_back_to_back();
    test_stall();
    test_guard();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
